// File: rtl/jtag_bscan_tap.sv
// IEEE 1149.1-style TAP controller with an integrated boundary-scan register.
// Supports EXTEST, SAMPLE/PRELOAD, IDCODE, INTEST and BYPASS; unknown opcodes act as BYPASS.
module jtag_bscan_tap #(
  parameter int unsigned IR_WIDTH = 4,
  parameter int unsigned N_IN     = 5,
  parameter int unsigned N_OUT    = 4,
  parameter logic [31:0] IDCODE   = 32'h1234_5093
) (
  input  logic                TCK,
  input  logic                TRST,
  input  logic                TMS,
  input  logic                TDI,
  output logic                TDO,
  input  logic [N_IN-1:0]     pin_in,
  output logic [N_IN-1:0]     core_in,
  input  logic [N_OUT-1:0]    core_out,
  output logic [N_OUT-1:0]    pin_out,
  output logic [3:0]          tap_state,
  output logic [IR_WIDTH-1:0] ir_value
);

  localparam int unsigned BSR_LEN = N_IN + N_OUT;

  localparam logic [IR_WIDTH-1:0] OP_EXTEST = '0;
  localparam logic [IR_WIDTH-1:0] OP_SAMPLE = IR_WIDTH'(1);
  localparam logic [IR_WIDTH-1:0] OP_IDCODE = IR_WIDTH'(2);
  localparam logic [IR_WIDTH-1:0] OP_INTEST = IR_WIDTH'(3);

  typedef enum logic [3:0] {
    TEST_LOGIC_RESET = 4'd0,
    RUN_IDLE         = 4'd1,
    SELECT_DR        = 4'd2,
    CAPTURE_DR       = 4'd3,
    SHIFT_DR         = 4'd4,
    EXIT1_DR         = 4'd5,
    PAUSE_DR         = 4'd6,
    EXIT2_DR         = 4'd7,
    UPDATE_DR        = 4'd8,
    SELECT_IR        = 4'd9,
    CAPTURE_IR       = 4'd10,
    SHIFT_IR         = 4'd11,
    EXIT1_IR         = 4'd12,
    PAUSE_IR         = 4'd13,
    EXIT2_IR         = 4'd14,
    UPDATE_IR        = 4'd15
  } tap_state_t;

  tap_state_t           state;
  tap_state_t           nxt;
  logic [IR_WIDTH-1:0]  ir_shift;
  logic [IR_WIDTH-1:0]  ir_reg;
  logic [BSR_LEN-1:0]   bsr_shift;
  logic [BSR_LEN-1:0]   bsr_upd;
  logic [31:0]          id_shift;
  logic                 byp;

  logic is_extest, is_sample, is_intest, is_idcode, is_bsr;
  logic rst;

  function automatic tap_state_t next_state(input tap_state_t s, input logic tms);
    case (s)
      TEST_LOGIC_RESET: next_state = tms ? TEST_LOGIC_RESET : RUN_IDLE;
      RUN_IDLE:         next_state = tms ? SELECT_DR : RUN_IDLE;
      SELECT_DR:        next_state = tms ? SELECT_IR : CAPTURE_DR;
      CAPTURE_DR:       next_state = tms ? EXIT1_DR  : SHIFT_DR;
      SHIFT_DR:         next_state = tms ? EXIT1_DR  : SHIFT_DR;
      EXIT1_DR:         next_state = tms ? UPDATE_DR : PAUSE_DR;
      PAUSE_DR:         next_state = tms ? EXIT2_DR  : PAUSE_DR;
      EXIT2_DR:         next_state = tms ? UPDATE_DR : SHIFT_DR;
      UPDATE_DR:        next_state = tms ? SELECT_DR : RUN_IDLE;
      SELECT_IR:        next_state = tms ? TEST_LOGIC_RESET : CAPTURE_IR;
      CAPTURE_IR:       next_state = tms ? EXIT1_IR  : SHIFT_IR;
      SHIFT_IR:         next_state = tms ? EXIT1_IR  : SHIFT_IR;
      EXIT1_IR:         next_state = tms ? UPDATE_IR : PAUSE_IR;
      PAUSE_IR:         next_state = tms ? EXIT2_IR  : PAUSE_IR;
      EXIT2_IR:         next_state = tms ? UPDATE_IR : SHIFT_IR;
      UPDATE_IR:        next_state = tms ? SELECT_DR : RUN_IDLE;
      default:          next_state = TEST_LOGIC_RESET;
    endcase
  endfunction

  assign nxt = next_state(state, TMS);
  // Entering TEST_LOGIC_RESET by TMS clears the same state as TRST does.
  assign rst = TRST || (nxt == TEST_LOGIC_RESET);

  assign is_extest = (ir_reg == OP_EXTEST);
  assign is_sample = (ir_reg == OP_SAMPLE);
  assign is_intest = (ir_reg == OP_INTEST);
  assign is_idcode = (ir_reg == OP_IDCODE);
  assign is_bsr    = is_extest || is_sample || is_intest;

  always_ff @(posedge TCK) begin
    if (rst) begin
      state     <= TEST_LOGIC_RESET;
      ir_shift  <= '0;
      ir_reg    <= OP_IDCODE;
      bsr_shift <= '0;
      bsr_upd   <= '0;
      id_shift  <= '0;
      byp       <= 1'b0;
    end else begin
      state <= nxt;
      case (state)
        CAPTURE_IR: ir_shift <= IR_WIDTH'(1);
        SHIFT_IR:   ir_shift <= {TDI, ir_shift[IR_WIDTH-1:1]};
        UPDATE_IR:  ir_reg   <= ir_shift;
        CAPTURE_DR: begin
          if (is_intest)      bsr_shift <= {core_out, bsr_upd[N_IN-1:0]};
          else if (is_bsr)    bsr_shift <= {core_out, pin_in};
          else if (is_idcode) id_shift  <= IDCODE;
          else                byp       <= 1'b0;
        end
        SHIFT_DR: begin
          if (is_bsr)         bsr_shift <= {TDI, bsr_shift[BSR_LEN-1:1]};
          else if (is_idcode) id_shift  <= {TDI, id_shift[31:1]};
          else                byp       <= TDI;
        end
        UPDATE_DR: if (is_bsr) bsr_upd <= bsr_shift;
        default: ;
      endcase
    end
  end

  // Pin/core muxing and TDO are combinational from the registers above.
  always_comb begin
    TDO = 1'b0;
    if (state == SHIFT_IR)
      TDO = ir_shift[0];
    else if (state == SHIFT_DR)
      TDO = is_bsr ? bsr_shift[0] : (is_idcode ? id_shift[0] : byp);
  end

  assign core_in   = is_intest ? bsr_upd[N_IN-1:0] : pin_in;
  assign pin_out   = (is_extest || is_intest) ? bsr_upd[BSR_LEN-1:N_IN] : core_out;
  assign tap_state = state;
  assign ir_value  = ir_reg;

endmodule

// File: tb/tb_jtag_bscan_tap.sv
// Directed bench for jtag_bscan_tap: stimulus pushes expected values, a negedge monitor compares.
module tb_jtag_bscan_tap;

  logic       TCK = 1'b0;
  logic       TRST = 1'b0;
  logic       TMS = 1'b1;
  logic       TDI = 1'b0;
  logic       TDO;
  logic [4:0] pin_in = '0;
  logic [4:0] core_in;
  logic [3:0] core_out = '0;
  logic [3:0] pin_out;
  logic [3:0] tap_state;
  logic [3:0] ir_value;

  jtag_bscan_tap #(.IR_WIDTH(4), .N_IN(5), .N_OUT(4), .IDCODE(32'h1234_5093)) dut (
    .TCK(TCK), .TRST(TRST), .TMS(TMS), .TDI(TDI), .TDO(TDO),
    .pin_in(pin_in), .core_in(core_in), .core_out(core_out), .pin_out(pin_out),
    .tap_state(tap_state), .ir_value(ir_value)
  );

  always #5 TCK = ~TCK;

  typedef enum int {K_TDO, K_STATE, K_IR, K_CORE_IN, K_PIN_OUT} kind_t;
  typedef struct {
    string       name;
    kind_t       kind;
    logic [31:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // Monitor: every pending expectation is checked at the falling edge.
  initial begin
    forever begin
      @(negedge TCK);
      while (exp_q.size() > 0) begin
        exp_t        e;
        logic [31:0] act;
        e = exp_q.pop_front();
        case (e.kind)
          K_TDO:     act = 32'(TDO);
          K_STATE:   act = 32'(tap_state);
          K_IR:      act = 32'(ir_value);
          K_CORE_IN: act = 32'(core_in);
          default:   act = 32'(pin_out);
        endcase
        total++;
        if (act !== e.val) begin
          bad++;
          $display("FAIL %s: got %0h expected %0h", e.name, act, e.val);
        end
      end
    end
  end

  task automatic expect_val(input string nm, input kind_t k, input logic [31:0] v);
    exp_t e;
    e.name = nm;
    e.kind = k;
    e.val  = v;
    exp_q.push_back(e);
  endtask

  task automatic step(input logic tms, input logic tdi);
    TMS = tms;
    TDI = tdi;
    @(posedge TCK);
    #1;
  endtask

  task automatic reset_tap();
    TRST = 1'b1;
    step(1'b1, 1'b0);
    TRST = 1'b0;
  endtask

  // From RUN_IDLE: shift a 4-bit IR (bit 0 first), update, back to RUN_IDLE.
  task automatic load_ir(input logic [3:0] op);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(i == 3, op[i]);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
  endtask

  // From RUN_IDLE: scan n DR bits (bit 0 first), optionally checking TDO per bit.
  task automatic scan_dr(input string nm, input logic [31:0] din, input int n,
                         input logic [31:0] exp_tdo, input bit chk);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    for (int i = 0; i < n; i++) begin
      if (chk) expect_val($sformatf("%s_tdo%0d", nm, i), K_TDO, 32'(exp_tdo[i]));
      step(i == n - 1, din[i]);
    end
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
  endtask

  initial begin
    int wait_cyc;
    @(posedge TCK);
    #1;

    // Reset state and IDCODE read
    reset_tap();
    expect_val("rst_state", K_STATE, 32'd0);
    expect_val("rst_ir", K_IR, 32'h2);
    expect_val("rst_tdo", K_TDO, 32'd0);
    step(1'b0, 1'b0);
    scan_dr("idcode", 32'h0, 32, 32'h1234_5093, 1'b1);

    // Functional pass-through after reset
    reset_tap();
    pin_in = 5'b10011;
    core_out = 4'b0011;
    #1;
    expect_val("pass_core_in", K_CORE_IN, 32'h13);
    expect_val("pass_pin_out", K_PIN_OUT, 32'h3);
    step(1'b0, 1'b0);

    // SAMPLE/PRELOAD then INTEST
    load_ir(4'b0001);
    expect_val("sample_ir", K_IR, 32'h1);
    expect_val("sample_pin_out", K_PIN_OUT, 32'h3);
    scan_dr("preload", 32'h169, 9, 32'h0, 1'b0);
    load_ir(4'b0011);
    expect_val("intest_ir", K_IR, 32'h3);
    expect_val("intest_core_in", K_CORE_IN, 32'h09);
    expect_val("intest_pin_out", K_PIN_OUT, 32'hB);

    // EXTEST sample of pins and core outputs
    load_ir(4'b0000);
    pin_in = 5'b11010;
    core_out = 4'b0101;
    #1;
    expect_val("extest_pin_out_pre", K_PIN_OUT, 32'hB);
    expect_val("extest_core_in", K_CORE_IN, 32'h1A);
    scan_dr("extest", 32'h0, 9, 32'h0BA, 1'b1);
    expect_val("extest_pin_out_post", K_PIN_OUT, 32'h0);

    // BYPASS and an undefined opcode
    load_ir(4'b1111);
    scan_dr("bypass", 32'hD, 4, 32'hA, 1'b1);
    load_ir(4'b0111);
    expect_val("undef_ir", K_IR, 32'h7);
    scan_dr("undef", 32'hD, 4, 32'hA, 1'b1);

    // Five TMS=1 from SHIFT_DR
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    expect_val("in_shift_dr", K_STATE, 32'd4);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
    expect_val("tms_rst_state", K_STATE, 32'd0);
    expect_val("tms_rst_ir", K_IR, 32'h2);

    // TRST mid-BSR-shift clears the update stage
    step(1'b0, 1'b0);
    load_ir(4'b0001);
    scan_dr("preload_ones", 32'h1FF, 9, 32'h0, 1'b0);
    load_ir(4'b0000);
    expect_val("ones_pin_out", K_PIN_OUT, 32'hF);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    reset_tap();
    expect_val("trst_state", K_STATE, 32'd0);
    expect_val("trst_ir", K_IR, 32'h2);
    expect_val("trst_pin_out", K_PIN_OUT, 32'h5);
    expect_val("trst_core_in", K_CORE_IN, 32'h1A);
    step(1'b0, 1'b0);
    load_ir(4'b0011);
    expect_val("trst_upd_in", K_CORE_IN, 32'h0);
    expect_val("trst_upd_out", K_PIN_OUT, 32'h0);
    step(1'b0, 1'b0);

    wait_cyc = 0;
    while (exp_q.size() > 0 && wait_cyc < 20) begin
      @(posedge TCK);
      wait_cyc++;
    end
    if (exp_q.size() > 0) begin
      bad++;
      $display("FAIL drain: pending=%0d expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/jtag_bscan_tap.md
# jtag_bscan_tap

Parametrised IEEE 1149.1-style TAP controller with an integrated boundary-scan register (BSR). It sits between the board pins (SW/LED) and the core logic in the on-board top. It generalises the fixed 4-bit-IR / 9-cell BSR arrangement:
- IR width, input and output cell counts and IDCODE are parameters.
- It adds EXTEST, IDCODE and BYPASS alongside SAMPLE/PRELOAD and INTEST.

## Interface

- IR_WIDTH, 4: instruction register width, ≥3.
- N_IN, 5: number of input boundary cells (pin → core).
- N_OUT, 4: number of output boundary cells (core → pin).
- IDCODE, 32'h1234_5093: device ID. Bit 0 must be 1.

Ports:
- TCK  in  1  test clock, the only clock.
- TRST  in  1  synchronous, active-high reset: forces TEST_LOGIC_RESET on the next TCK rising edge.
- TMS  in  1  mode select.
- TDI  in  1  serial data in.
- TDO  out  1  serial data out.
- pin_in  in  N_IN  board input pins.
- core_in  out  N_IN  inputs presented to the core.
- core_out  in  N_OUT  core outputs.
- pin_out  out  N_OUT  board output pins.
- tap_state  out  4  current TAP state code.
- ir_value  out  IR_WIDTH  current (updated) instruction.

## Operation

- **TAP FSM:** standard 16 states, advanced on each TCK rising edge by TMS:
  - TEST_LOGIC_RESET(0) →0 RUN_IDLE(1).
  - SELECT_DR(2): →0 CAPTURE_DR(3), →1 SELECT_IR(9).
  - DR path: CAPTURE_DR(3) → SHIFT_DR(4), EXIT1_DR(5), PAUSE_DR(6), EXIT2_DR(7), UPDATE_DR(8).
  - IR path: SELECT_IR(9) →1 TEST_LOGIC_RESET. CAPTURE_IR(10) → SHIFT_IR(11), EXIT1_IR(12), PAUSE_IR(13), EXIT2_IR(14), UPDATE_IR(15).
  - UPDATE_x →1 SELECT_DR, →0 RUN_IDLE.
  - Five consecutive TMS=1 reach TEST_LOGIC_RESET from any state.
- **Opcodes:**
  - EXTEST = all zeros.
  - SAMPLE/PRELOAD = 1.
  - IDCODE = 2.
  - INTEST = 3.
  - BYPASS = all ones.
  - Any other code behaves as BYPASS.
- **IR:**
  - CAPTURE_IR loads {0…0,1}.
  - SHIFT_IR shifts TDI in at the MSB and out at the LSB.
  - UPDATE_IR copies the shift stage to ir_value.
  - In TEST_LOGIC_RESET, ir_value = IDCODE opcode.
- **DR selection by ir_value:**
  - BYPASS: 1-bit register, captures 0.
  - IDCODE: 32-bit register, captures IDCODE.
  - EXTEST, SAMPLE/PRELOAD, INTEST: BSR, N_IN+N_OUT bits. Cells [N_IN-1:0] are input cells; cells [N_IN+N_OUT-1:N_IN] are output cells.
- **BSR capture:**
  - SAMPLE and EXTEST capture {core_out, pin_in}.
  - INTEST captures {core_out, upd_in}, i.e. input cells reload their own update value.
- **BSR shift:** TDI enters the MSB; the LSB drives TDO. After N shifts, the k-th shifted bit sits in cell k (N = BSR length).
- **BSR update:** on UPDATE_DR, the BSR shift stage is copied to the update stage {upd_out, upd_in} for any BSR instruction. The update stage is not altered otherwise.
- **Pin/core muxing:**
  - core_in = (INTEST) ? upd_in : pin_in.
  - pin_out = (EXTEST or INTEST) ? upd_out : core_out.
- **TDO:**
  - In SHIFT_IR: LSB of the IR shift stage.
  - In SHIFT_DR: LSB of the selected DR.
  - Otherwise: 0.

## Timing

- All state, shift, capture and update actions happen on the TCK rising edge at which tap_state equals the named state.
  - The edge that leaves SHIFT_x for EXIT1_x still performs a shift.
  - Capture happens on the edge leaving CAPTURE_x.
  - Update happens on the edge leaving UPDATE_x.
- TDO, core_in and pin_out are combinational from registers and the mux inputs. Pin-to-core pass-through has zero-cycle latency.
- A new instruction takes effect on the mux on the edge leaving UPDATE_IR. There is no extra pipeline stage.
- **Reset (TRST=1 at an edge, or TEST_LOGIC_RESET entry):**
  - tap_state = 0.
  - ir_value = IDCODE opcode.
  - BSR shift and update stages = 0.
  - TDO = 0.
  - Muxes therefore pass pin_in→core_in and core_out→pin_out.
- TRST asserted mid-shift aborts the shift. No update occurs and the update stage is cleared.
- TRST has priority over TMS.
- Pause states hold all shift stages unchanged for any number of cycles.

## Test plan

- **IDCODE read.** Stimulus: TRST pulse, then TMS 0,1,0,0, then 32 shifts. Response: TDO sequence = 32'h1234_5093 LSB first, i.e. 1,1,0,0,1,0,0,1,0,0,0,0,1,0,1,0,…
- **Functional pass-through.** Stimulus: after reset, pin_in=5'b10011 and core_out=4'b0011. Response: core_in=5'b10011 and pin_out=4'b0011 in the same cycle.
- **SAMPLE/PRELOAD then INTEST.**
  - Load IR shifting 1,0,0,0. Preload BSR shifting 1,0,0,1,0,1,1,0,1.
  - Load IR shifting 1,1,0,0.
  - Response: ir_value=4'b0011, core_in=5'b01001, pin_out=4'b1011.
- **EXTEST sample.** Stimulus: pin_in=5'b11010 and core_out=4'b0101 during CAPTURE_DR under EXTEST. Response: the first 9 TDO bits read 0,1,0,1,1,1,0,1,0.
- **BYPASS delay.** Stimulus: IR shifts 1,1,1,1, then DR shift of 1,0,1,1. Response: TDO = 0,1,0,1, a one-cycle delay with the captured 0 leading. An undefined opcode (e.g. 4'b0111) gives the same result.
- **Reset behaviour.**
  - Five TMS=1 from SHIFT_DR give tap_state=0 and ir_value=4'b0010.
  - TRST asserted mid-BSR-shift gives an update stage of 0 and pin_out=core_out.
